// File: rtl/jt51_timer_pkg.sv
// jt51_timer_pkg: default geometry of the JT51 timer bank and the
// per-timer control bundle shared by the bank and its channels.
package jt51_timer_pkg;

  localparam int JT51_NT_DEF   = 2;
  localparam int JT51_W_DEF    = 10;
  localparam int JT51_PDIV_DEF = 16;

  typedef struct packed {
    logic load;
    logic auto_reload;
    logic irq_en;
    logic clr_flag;
  } timer_ctrl_t;

endpackage

// File: rtl/jt51_timer_ch.sv
// jt51_timer_ch: one up-counting timer channel. It holds the load edge
// detector, the counter, running, sticky flag and the one-clk overflow.
// Ports: clk, rst (sync, high), cen_i, tick_i (shared prescaler tick),
//   value_i (preset), ctrl_i (load/auto_reload/irq_en/clr_flag),
//   flag_o, overflow_o, running_o, irq_req_o (flag & irq_en).
module jt51_timer_ch
  import jt51_timer_pkg::*;
#(
  parameter int W = JT51_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen_i,
  input  logic         tick_i,
  input  logic [W-1:0] value_i,
  input  timer_ctrl_t  ctrl_i,
  output logic         flag_o,
  output logic         overflow_o,
  output logic         running_o,
  output logic         irq_req_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ld_q, ld_d;
  logic         run_q, run_d;
  logic         flag_q, flag_d;
  logic         ovf_q, ovf_d;
  logic         rise, fall, adv;

  always_comb begin
    rise   = cen_i & ctrl_i.load & ~ld_q;
    fall   = cen_i & ~ctrl_i.load & ld_q;
    // load edges take precedence over a coincident tick
    adv    = tick_i & run_q & ~rise & ~fall;
    ld_d   = cen_i ? ctrl_i.load : ld_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    ovf_d  = 1'b0;
    unique case (1'b1)
      rise: begin
        cnt_d = value_i;
        run_d = 1'b1;
      end
      fall: begin
        run_d = 1'b0;
      end
      adv: begin
        if (&cnt_q) begin
          ovf_d = 1'b1;
          cnt_d = value_i;
          run_d = ctrl_i.auto_reload;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // a new overflow beats a simultaneous clear
    flag_d = ovf_d | (flag_q & ~ctrl_i.clr_flag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      ld_q   <= 1'b0;
      run_q  <= 1'b0;
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ld_q   <= ld_d;
      run_q  <= run_d;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign flag_o     = flag_q;
  assign overflow_o = ovf_q;
  assign running_o  = run_q;
  assign irq_req_o  = flag_q & ctrl_i.irq_en;

endmodule

// File: rtl/jt51_timer_bank.sv
// jt51_timer_bank: NT up-counting timers sharing one cen prescaler,
// with sticky flags and a registered active-low combined IRQ.
// Ports: clk, rst (sync, high), cen, value[NT*W], load, auto_reload,
//   irq_en, clr_flag (per timer) -> flag, overflow, running, irq_n.
// Option JT51_TIMER_CSM_EN adds csm (in) and csm_kon (out): a key-on
//   pulse coincident with overflow[0] while csm is high.
module jt51_timer_bank
  import jt51_timer_pkg::*;
#(
  parameter int NT   = JT51_NT_DEF,
  parameter int W    = JT51_W_DEF,
  parameter int PDIV = JT51_PDIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [NT*W-1:0] value,
  input  logic [NT-1:0]   load,
  input  logic [NT-1:0]   auto_reload,
  input  logic [NT-1:0]   irq_en,
  input  logic [NT-1:0]   clr_flag,
  output logic [NT-1:0]   flag,
  output logic [NT-1:0]   overflow,
  output logic [NT-1:0]   running,
  output logic            irq_n
`ifdef JT51_TIMER_CSM_EN
  ,
  input  logic            csm,
  output logic            csm_kon
`endif
);

  localparam int PW = (PDIV > 1) ? $clog2(PDIV) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PDIV - 1);

  logic [PW-1:0] psc_q, psc_d;
  logic          tick;
  logic          irq_n_q, irq_n_d;
  logic [NT-1:0] irq_req;

  always_comb begin
    tick    = cen & (psc_q == PLAST);
    psc_d   = psc_q;
    if (cen) begin
      psc_d = (psc_q == PLAST) ? '0 : psc_q + 1'b1;
    end
    irq_n_d = ~|irq_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      irq_n_q <= 1'b1;
    end else begin
      psc_q   <= psc_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign irq_n = irq_n_q;

  for (genvar i = 0; i < NT; i++) begin : g_ch
    timer_ctrl_t ctrl;

    assign ctrl = '{
      load:        load[i],
      auto_reload: auto_reload[i],
      irq_en:      irq_en[i],
      clr_flag:    clr_flag[i]
    };

    jt51_timer_ch #(
      .W(W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .cen_i      (cen),
      .tick_i     (tick),
      .value_i    (value[i*W +: W]),
      .ctrl_i     (ctrl),
      .flag_o     (flag[i]),
      .overflow_o (overflow[i]),
      .running_o  (running[i]),
      .irq_req_o  (irq_req[i])
    );
  end

`ifdef JT51_TIMER_CSM_EN
  // overflow[0] is already a one-clk registered pulse, so gating it
  // keeps csm_kon exactly aligned and zero through reset
  assign csm_kon = csm & overflow[0];
`endif

endmodule

// File: tb/tb_jt51_timer_bank.sv
// tb_jt51_timer_bank: scenario tasks plus randomized traffic checked
// against a remaining-ticks reference model of the timer bank.
module tb_jt51_timer_bank;

  localparam int NT   = 2;
  localparam int W    = 10;
  localparam int PDIV = 16;
  localparam int FULL = 1 << W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cen = 1'b0;
  logic [NT*W-1:0] value = '0;
  logic [NT-1:0]   load = '0;
  logic [NT-1:0]   auto_reload = '0;
  logic [NT-1:0]   irq_en = '0;
  logic [NT-1:0]   clr_flag = '0;
  logic [NT-1:0]   flag, overflow, running;
  logic            irq_n;
`ifdef JT51_TIMER_CSM_EN
  logic            csm = 1'b0;
  logic            csm_kon;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit cen_rand = 1'b0;

  // reference model: ticks remaining until overflow per timer
  int            m_phase = 0;
  int            m_rem[NT];
  logic [NT-1:0] m_run = '0;
  logic [NT-1:0] m_flag = '0;
  logic [NT-1:0] m_ovf = '0;
  logic [NT-1:0] m_prev = '0;
  logic          m_irqn = 1'b1;

  always #5 clk = ~clk;

  jt51_timer_bank #(
    .NT(NT), .W(W), .PDIV(PDIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .value       (value),
    .load        (load),
    .auto_reload (auto_reload),
    .irq_en      (irq_en),
    .clr_flag    (clr_flag),
    .flag        (flag),
    .overflow    (overflow),
    .running     (running),
    .irq_n       (irq_n)
`ifdef JT51_TIMER_CSM_EN
    ,
    .csm         (csm),
    .csm_kon     (csm_kon)
`endif
  );

  task automatic model_update();
    bit tick, rise, fall;
    int v;
    if (rst) begin
      m_phase = 0;
      m_run   = '0;
      m_flag  = '0;
      m_ovf   = '0;
      m_prev  = '0;
      m_irqn  = 1'b1;
      return;
    end
    m_irqn = ((m_flag & irq_en) == '0);
    tick = cen && (m_phase == PDIV - 1);
    for (int i = 0; i < NT; i++) begin
      v = int'(value[i*W +: W]);
      rise = cen && load[i] && !m_prev[i];
      fall = cen && !load[i] && m_prev[i];
      m_ovf[i] = 1'b0;
      if (rise) begin
        m_rem[i] = FULL - v;
        m_run[i] = 1'b1;
      end else if (fall) begin
        m_run[i] = 1'b0;
      end else if (tick && m_run[i]) begin
        m_rem[i] = m_rem[i] - 1;
        if (m_rem[i] == 0) begin
          m_ovf[i] = 1'b1;
          m_rem[i] = FULL - v;
          m_run[i] = auto_reload[i];
        end
      end
      if (m_ovf[i]) m_flag[i] = 1'b1;
      else if (clr_flag[i]) m_flag[i] = 1'b0;
      if (cen) m_prev[i] = load[i];
    end
    if (cen) m_phase = (m_phase + 1) % PDIV;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    cen = cen_rand ? 1'($urandom_range(0, 1)) : ~cen;
  endtask

  function automatic bit next_tick();
    return cen && (m_phase == PDIV - 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (flag !== '0) begin
      errors++;
      $display("FAIL reset_flag got=%b exp=00", flag);
    end
    checks++;
    if (overflow !== '0) begin
      errors++;
      $display("FAIL reset_ovf got=%b exp=00", overflow);
    end
    checks++;
    if (running !== '0) begin
      errors++;
      $display("FAIL reset_run got=%b exp=00", running);
    end
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_irq_n got=%b exp=1", irq_n);
    end
    rst = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_oneshot();
    int n, ovf_at, pulses;
    logic c;
    load = '0;
    auto_reload = '0;
    value[0 +: W] = W'(1020);
    repeat (4) step();
    for (int k = 0; k < 64; k++) begin
      if (cen && m_phase == 0) break;
      step();
    end
    load[0] = 1'b1;
    n = 0;
    ovf_at = -1;
    pulses = 0;
    for (int k = 0; k < 400; k++) begin
      c = cen;
      step();
      if (c) n++;
      if (overflow[0]) begin
        pulses++;
        if (ovf_at < 0) ovf_at = n;
      end
      checks++;
      if ({flag, overflow, running, irq_n} !==
          {m_flag, m_ovf, m_run, m_irqn}) begin
        errors++;
        $display("FAIL oneshot_model cyc=%0d got=%b exp=%b", cyc,
                 {flag, overflow, running, irq_n},
                 {m_flag, m_ovf, m_run, m_irqn});
      end
    end
    checks++;
    if (ovf_at != 64) begin
      errors++;
      $display("FAIL oneshot_cen got=%0d exp=64", ovf_at);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL oneshot_pulses got=%0d exp=1", pulses);
    end
    checks++;
    if (flag[0] !== 1'b1 || running[0] !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_end got flag=%b run=%b exp flag=1 run=0",
               flag[0], running[0]);
    end
  endtask

  task automatic test_auto();
    int n, pulses, last;
    logic c;
    value[W +: W] = W'(1022);
    auto_reload[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (cen) break;
      step();
    end
    load[1] = 1'b1;
    n = 0;
    pulses = 0;
    last = 0;
    for (int k = 0; k < 1000; k++) begin
      c = cen;
      step();
      if (c) n++;
      checks++;
      if (running[1] !== 1'b1) begin
        errors++;
        $display("FAIL auto_running cyc=%0d got=%b exp=1", cyc, running[1]);
      end
      checks++;
      if ({flag, overflow, running} !== {m_flag, m_ovf, m_run}) begin
        errors++;
        $display("FAIL auto_model cyc=%0d got=%b exp=%b", cyc,
                 {flag, overflow, running}, {m_flag, m_ovf, m_run});
      end
      if (overflow[1]) begin
        if (pulses > 0) begin
          checks++;
          if (n - last != 32) begin
            errors++;
            $display("FAIL auto_period got=%0d exp=32", n - last);
          end
        end
        last = n;
        pulses++;
        if (pulses == 6) break;
      end
    end
    checks++;
    if (pulses != 6) begin
      errors++;
      $display("FAIL auto_count got=%0d exp=6", pulses);
    end
    load[1] = 1'b0;
    auto_reload[1] = 1'b0;
    repeat (4) step();
  endtask

  task automatic arm0(input int v);
    load[0] = 1'b0;
    clr_flag = '1;
    repeat (4) step();
    clr_flag = '0;
    value[0 +: W] = W'(v);
    for (int k = 0; k < 4; k++) begin
      if (cen) break;
      step();
    end
    load[0] = 1'b1;
    step();
  endtask

  task automatic test_irq();
    irq_en = 2'b01;
    auto_reload[0] = 1'b0;
    arm0(1023);
    for (int k = 0; k < 200; k++) begin
      if (flag[0]) break;
      step();
    end
    checks++;
    if (flag[0] !== 1'b1 || irq_n !== 1'b1) begin
      errors++;
      $display("FAIL irq_flag_seen got flag=%b irq_n=%b exp 1 1",
               flag[0], irq_n);
    end
    step();
    checks++;
    if (irq_n !== 1'b0) begin
      errors++;
      $display("FAIL irq_assert got=%b exp=0", irq_n);
    end
    clr_flag[0] = 1'b1;
    step();
    clr_flag[0] = 1'b0;
    checks++;
    if (flag[0] !== 1'b0 || irq_n !== 1'b0) begin
      errors++;
      $display("FAIL irq_clr1 got flag=%b irq_n=%b exp 0 0",
               flag[0], irq_n);
    end
    step();
    checks++;
    if (irq_n !== 1'b1) begin
      errors++;
      $display("FAIL irq_clr2 got=%b exp=1", irq_n);
    end
    irq_en = '0;
    arm0(1023);
    for (int k = 0; k < 200; k++) begin
      step();
      checks++;
      if (irq_n !== 1'b1) begin
        errors++;
        $display("FAIL irq_masked cyc=%0d got=%b exp=1", cyc, irq_n);
      end
    end
    checks++;
    if (flag[0] !== 1'b1) begin
      errors++;
      $display("FAIL irq_masked_flag got=%b exp=1", flag[0]);
    end
  endtask

  task automatic test_simul();
    int n;
    logic c;
    arm0(1023);
    for (int k = 0; k < 100; k++) begin
      if (next_tick()) break;
      step();
    end
    clr_flag[0] = 1'b1;
    step();
    clr_flag[0] = 1'b0;
    checks++;
    if (overflow[0] !== 1'b1 || flag[0] !== 1'b1) begin
      errors++;
      $display("FAIL simul_clr_set got ovf=%b flag=%b exp 1 1",
               overflow[0], flag[0]);
    end
    step();
    checks++;
    if (flag[0] !== 1'b1) begin
      errors++;
      $display("FAIL simul_clr_hold got=%b exp=1", flag[0]);
    end
    load[0] = 1'b0;
    repeat (4) step();
    value[0 +: W] = W'(1020);
    for (int k = 0; k < 100; k++) begin
      if (next_tick()) break;
      step();
    end
    load[0] = 1'b1;
    step();
    n = -1;
    for (int k = 0; k < 400; k++) begin
      c = cen;
      step();
      if (c) n = (n < 0) ? 1 : n + 1;
      if (overflow[0]) break;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL simul_load_tick got=%0d exp=64", n);
    end
    arm0(1023);
    for (int k = 0; k < 100; k++) begin
      if (next_tick()) break;
      step();
    end
    load[0] = 1'b0;
    step();
    checks++;
    if (overflow[0] !== 1'b0 || flag[0] !== 1'b0 || running[0] !== 1'b0) begin
      errors++;
      $display("FAIL simul_stop got ovf=%b flag=%b run=%b exp 0 0 0",
               overflow[0], flag[0], running[0]);
    end
    for (int k = 0; k < 80; k++) begin
      step();
      checks++;
      if (overflow[0] !== 1'b0) begin
        errors++;
        $display("FAIL simul_stop_quiet cyc=%0d got=1 exp=0", cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ticks;
    irq_en = 2'b10;
    value[W +: W] = W'(1023);
    auto_reload[1] = 1'b1;
    load[1] = 1'b1;
    arm0(1020);
    ticks = 0;
    for (int k = 0; k < 400; k++) begin
      if (ticks == 3) break;
      if (next_tick()) ticks++;
      step();
    end
    repeat (2) step();
    checks++;
    if (irq_n !== 1'b0 || running[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got irq_n=%b run0=%b exp 0 1",
               irq_n, running[0]);
    end
    rst = 1'b1;
    load = '0;
    step();
    checks++;
    if ({flag, overflow, running, irq_n} !== 7'b0000001) begin
      errors++;
      $display("FAIL rstmid_vals got=%b exp=0000001",
               {flag, overflow, running, irq_n});
    end
    step();
    rst = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      checks++;
      if (overflow !== '0 || irq_n !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_quiet cyc=%0d got ovf=%b irq_n=%b exp 00 1",
                 cyc, overflow, irq_n);
      end
    end
    auto_reload = '0;
  endtask

  task automatic test_random();
    cen_rand = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NT; i++) begin
        if ($urandom_range(0, 15) == 0) load[i] = ~load[i];
        if ($urandom_range(0, 31) == 0)
          value[i*W +: W] = W'($urandom_range(1016, 1023));
        if ($urandom_range(0, 63) == 0)
          auto_reload[i] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 63) == 0)
          irq_en[i] = 1'($urandom_range(0, 1));
        clr_flag[i] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
      checks++;
      if ({flag, overflow, running, irq_n} !==
          {m_flag, m_ovf, m_run, m_irqn}) begin
        errors++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", cyc,
                 {flag, overflow, running, irq_n},
                 {m_flag, m_ovf, m_run, m_irqn});
      end
    end
    rst = 1'b0;
    clr_flag = '0;
    load = '0;
    cen_rand = 1'b0;
    repeat (4) step();
  endtask

`ifdef JT51_TIMER_CSM_EN
  task automatic test_csm();
    int pulses;
    csm = 1'b1;
    auto_reload[0] = 1'b1;
    arm0(1022);
    pulses = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (overflow[0]) pulses++;
      checks++;
      if (csm_kon !== overflow[0] || overflow[0] !== m_ovf[0]) begin
        errors++;
        $display("FAIL csm_on cyc=%0d got kon=%b ovf=%b exp %b %b",
                 cyc, csm_kon, overflow[0], m_ovf[0], m_ovf[0]);
      end
    end
    checks++;
    if (pulses == 0) begin
      errors++;
      $display("FAIL csm_pulses got=0 exp>0");
    end
    csm = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      checks++;
      if (csm_kon !== 1'b0) begin
        errors++;
        $display("FAIL csm_off cyc=%0d got=1 exp=0", cyc);
      end
    end
    auto_reload = '0;
    load = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_oneshot();
    test_auto();
    test_irq();
    test_simul();
    test_reset_mid();
`ifdef JT51_TIMER_CSM_EN
    test_csm();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt51_timer_bank.md
# jt51_timer_bank

Parametrised timer bank for the JT51 family. It provides NT up-counting timers with per-timer width-W presets, one-shot or auto-reload mode, sticky overflow flags and a combined open-drain-style IRQ. It generalises the fixed two-timer (A 10-bit / B 8-bit) YM2151 arrangement. It sits beside the register map and takes its presets and controls from the MMR block; flags and irq_n go to the CPU status read path.

## Interface
Parameters:
- NT, 2, number of timers (1..8)
- W, 10, counter width of every timer (4..16)
- PDIV, 16, number of cen pulses per timer tick (2..256)

Ports:
- clk  in  1  main clock; one clock domain only
- rst  in  1  reset, synchronous, active-high
- cen  in  1  clock enable; the prescaler advances only on cen
- value  in  NT*W  preset per timer; timer i at [i*W +: W]
- load  in  NT  level run control per timer; rising edge presets and starts, low stops
- auto_reload  in  NT  1 = reload and keep running on overflow; 0 = one-shot
- irq_en  in  NT  per-timer IRQ enable
- clr_flag  in  NT  one-clk pulse that clears the flag
- flag  out  NT  sticky overflow flag
- overflow  out  NT  one-clk overflow pulse
- running  out  NT  timer is counting
- irq_n  out  1  low while any (flag & irq_en) bit is set

## Operation
- Prescaler: free-running counter of 0..PDIV-1, advanced on cen. tick = cen && prescaler==PDIV-1. The prescaler is shared and is never reset by load.
- Per timer, the load edge detector samples load only on cen cycles.
  - Rising edge: cnt<=value[i], running<=1.
  - Falling edge: running<=0; cnt holds.
- On tick with running=1:
  - cnt != all-ones: cnt<=cnt+1.
  - cnt == all-ones: overflow is pulsed, flag<=1 and cnt<=value[i].
    - If auto_reload=1, running stays 1.
    - If auto_reload=0, running<=0. The timer stays stopped until the next load rising edge, even though load is still high.
- value changes while a timer is running take effect only at the next reload or load edge.
- clr_flag is not gated by cen. It clears the flag on the next clk edge.
- irq_n = ~|(flag & irq_en), registered.
- Priority when events coincide in one cycle:
  - A load rising edge and a tick: the load edge wins. cnt=value, with no increment.
  - clr_flag and an overflow set: the set wins, so the flag stays 1.
  - A load falling edge and an overflow tick: the stop wins. No overflow and no flag change.
- Reset: prescaler=0, cnt=0, running=0, flag=0, overflow=0, irq_n=1, edge-detect history=0. Reset during a count aborts it with no overflow.

## Timing
- flag, overflow and running are registered. They are visible the clk after the tick edge.
- overflow is high for exactly one clk. It is not stretched to the cen period.
- irq_n follows flag by one further clk. It follows clr_flag by two clks.
- Overflow period in auto-reload = (2^W − value) ticks = (2^W − value)·PDIV cen pulses.
- First tick after a load edge: 1..PDIV cen pulses, depending on the prescaler phase.

## Configuration
- JT51_TIMER_CSM_EN is the single compile-time option.
- Defined:
  - Adds input `csm` (1 bit) and output `csm_kon` (1 bit).
  - csm_kon pulses for one clk, coincident with overflow[0], when csm=1. This is used for CSM key-on of all slots.
  - csm_kon resets to 0.
- Undefined: both ports are absent and no logic is generated. All other behaviour is identical.

## Structure
- Package jt51_timer_pkg holds the default constants for NT, W and PDIV, plus the per-timer control struct (load, auto_reload, irq_en, clr_flag).
- Sub-module jt51_timer_ch holds one channel: edge detector, counter, running, flag and overflow. It is instantiated NT times in a generate loop.
- The parent holds the prescaler, the irq_n reduction and the CSM logic.

## Test plan
All scenarios use NT=2, W=10, PDIV=16, with cen every 2nd clk.
- One-shot overflow:
  - Stimulus: value0=1020, auto_reload=0. Raise load0 on a cen where the prescaler is 0.
  - Required: overflow0 pulses once on the 64th cen. Then flag0=1, running0=0, and cnt0 does not advance on later ticks.
- Auto-reload:
  - Stimulus: value1=1022, auto_reload=1.
  - Required: overflow1 pulses every 2 ticks (32 cen). running1 stays 1 across 5 periods.
- IRQ path:
  - Stimulus: irq_en0=1, flag0 set.
  - Required: irq_n=0 one clk after flag0=1. A clr_flag0 pulse gives flag0=0 after 1 clk and irq_n=1 after 2 clks. With irq_en0=0, irq_n stays 1 throughout.
- Simultaneous events:
  - Stimulus: drive clr_flag0 in the overflow clk.
  - Required: flag0 ends at 1.
  - Stimulus: assert a load rising edge on a tick cycle.
  - Required: cnt=value, with no increment.
- Reset mid-count:
  - Stimulus: assert rst 3 ticks into a 4-tick count.
  - Required: all outputs return to reset values (irq_n=1) and no overflow occurs.
- CSM (JT51_TIMER_CSM_EN defined):
  - Stimulus: csm=1, timer 0 overflows.
  - Required: csm_kon pulses for one clk together with overflow0.
  - Stimulus: csm=0.
  - Required: csm_kon stays 0.
